// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared types and constants for the multi-cycle ALU.
//           It holds the 4-bit opcode enum, which uses the same encoding as
//           the combinational ALU, and the FSM state constants.
// Ports   : none (package)
// Config  : ALU_FAST_MUL_EN is not used here. See alu_multicycle.
// Revision: 1.0  initial release
// ============================================================================
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_SEQ  = 4'h2,
    OP_SLT  = 4'h3,
    OP_SGT  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_NOT  = 4'h7,
    OP_SLTU = 4'h8,
    OP_SGTU = 4'h9,
    OP_SLL  = 4'hA,
    OP_SRL  = 4'hB,
    OP_SLA  = 4'hC,
    OP_SRA  = 4'hD,
    OP_MUL  = 4'hE,
    OP_DIV  = 4'hF
  } alu_op_e;

  // FSM state encoding
  typedef logic [1:0] alu_state_t;
  localparam alu_state_t ST_IDLE = 2'd0;
  localparam alu_state_t ST_EXEC = 2'd1;
  localparam alu_state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : alu_iter_muldiv
// Purpose : Iterative unsigned multiplier and divider. MUL uses shift-add and
//           DIV uses restoring division. Both share one iteration counter and
//           one set of datapath registers. Each takes WIDTH iterations after
//           start.
// Ports   : clk, rst_n          clock, async active-low reset
//           start, is_div, a, b load operands and begin (is_div selects DIV)
//           done                high during the final iteration cycle
//           res, rem            product/quotient and remainder. They are
//                               valid while done is high (rem is 0 for MUL)
// Config  : ALU_FAST_MUL_EN is not used here.
// Revision: 1.0  initial release
// ============================================================================
module alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] rem
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             div_q, div_d;
  // acc: MUL partial product / DIV partial remainder
  // mq : MUL multiplier (shifts right) / DIV dividend becoming quotient
  // opb: MUL multiplicand (shifts left) / DIV divisor (constant)
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   r_sub;

  assign done = busy_q & (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    div_d  = div_q;
    acc_d  = acc_q;
    mq_d   = mq_q;
    opb_d  = opb_q;
    r_sh   = {acc_q, mq_q[WIDTH-1]};
    r_sub  = r_sh - {1'b0, opb_q};
    if (start) begin
      cnt_d  = '0;
      busy_d = 1'b1;
      div_d  = is_div;
      acc_d  = '0;
      mq_d   = a;
      opb_d  = b;
    end else if (busy_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (done) begin
        busy_d = 1'b0;
      end
      if (div_q) begin
        // A partial remainder is always below the divisor, so the
        // difference fits back into WIDTH bits.
        if (r_sh >= {1'b0, opb_q}) begin
          acc_d = r_sub[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = r_sh[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (mq_q[0]) begin
          acc_d = acc_q + opb_q;
        end
        mq_d  = mq_q >> 1;
        opb_d = opb_q << 1;
      end
    end
  end

  // Outputs are the post-iteration values, so the result can be captured
  // at the same edge that completes the last iteration.
  assign res = div_q ? mq_d  : acc_d;
  assign rem = div_q ? acc_d : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      acc_q  <= '0;
      mq_q   <= '0;
      opb_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      div_q  <= div_d;
      acc_q  <= acc_d;
      mq_q   <= mq_d;
      opb_q  <= opb_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module  : alu_multicycle
// Purpose : Multi-cycle integer ALU for the EX stage. It has a valid/ready
//           handshake on the input and output sides. Basic ops retire one
//           cycle after accept. MUL and DIV iterate for WIDTH cycles. Flags
//           are registered together with the result.
// Ports   : clk, rst_n                 clock, async active-low reset
//           in_valid/in_ready, op, a, b  request side
//           out_valid/out_ready         response side
//           result, remainder           result (DIV: quotient + remainder)
//           zero, lt, ltu, overflow, div_zero  registered flags
// Config  : ALU_FAST_MUL_EN - MUL uses a combinational multiplier and
//           retires with basic-op latency. DIV is always iterative.
// Revision: 1.0  initial release
// ============================================================================
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             zero,
  output logic             lt,
  output logic             ltu,
  output logic             overflow,
  output logic             div_zero
);

`ifdef ALU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             zero_q, zero_d;
  logic             lt_q, lt_d;
  logic             ltu_q, ltu_d;
  logic             overflow_q, overflow_d;
  logic             div_zero_q, div_zero_d;

  alu_op_e          op_e;
  logic             accept;
  logic             b_is_zero;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_res;
  logic [WIDTH-1:0] iter_rem;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHAMT_W-1:0] shamt;
  logic             a_lt_b;
  logic             a_ltu_b;
  logic [WIDTH-1:0] basic_res;
  logic             basic_ovf;

  assign op_e      = alu_op_e'(op);
  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid & in_ready;
  assign b_is_zero = (b == '0);
  // DIV by zero skips iteration and retires like a basic op.
  assign iter_start = accept & (((op_e == OP_MUL) & !FAST_MUL) |
                                ((op_e == OP_DIV) & !b_is_zero));

  alu_iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (iter_start),
    .is_div (op_e == OP_DIV),
    .a      (a),
    .b      (b),
    .done   (iter_done),
    .res    (iter_res),
    .rem    (iter_rem)
  );

  // Single-cycle op mux. It also gives the fast-MUL and DIV-by-zero results.
  always_comb begin
    sum       = a + b;
    diff      = a - b;
    shamt     = b[SHAMT_W-1:0];
    a_lt_b    = $signed(a) < $signed(b);
    a_ltu_b   = a < b;
    basic_res = '0;
    basic_ovf = 1'b0;
    case (op_e)
      OP_ADD: begin
        basic_res = sum;
        basic_ovf = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        basic_res = diff;
        basic_ovf = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SEQ:  basic_res = {{(WIDTH-1){1'b0}}, a == b};
      OP_SLT:  basic_res = {{(WIDTH-1){1'b0}}, a_lt_b};
      OP_SGT:  basic_res = {{(WIDTH-1){1'b0}}, $signed(a) > $signed(b)};
      OP_AND:  basic_res = a & b;
      OP_OR:   basic_res = a | b;
      OP_NOT:  basic_res = ~a;
      OP_SLTU: basic_res = {{(WIDTH-1){1'b0}}, a_ltu_b};
      OP_SGTU: basic_res = {{(WIDTH-1){1'b0}}, a > b};
      OP_SLL:  basic_res = a << shamt;
      OP_SRL:  basic_res = a >> shamt;
      OP_SLA:  basic_res = a << shamt;
      OP_SRA:  basic_res = $unsigned($signed(a) >>> shamt);
      OP_MUL: begin
`ifdef ALU_FAST_MUL_EN
        basic_res = a * b;
`else
        basic_res = '0;
`endif
      end
      OP_DIV:  basic_res = '1;
      default: basic_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    zero_d      = zero_q;
    lt_d        = lt_q;
    ltu_d       = ltu_q;
    overflow_d  = overflow_q;
    div_zero_d  = div_zero_q;

    if ((state_q == ST_EXEC) && iter_done) begin
      state_d     = ST_DONE;
      result_d    = iter_res;
      remainder_d = iter_rem;
      zero_d      = (iter_res == '0);
    end else if (accept) begin
      // Compare flags and overflow come from the operands at accept time.
      lt_d       = a_lt_b;
      ltu_d      = a_ltu_b;
      overflow_d = basic_ovf;
      div_zero_d = (op_e == OP_DIV) & b_is_zero;
      if (iter_start) begin
        state_d = ST_EXEC;
      end else begin
        state_d     = ST_DONE;
        result_d    = basic_res;
        remainder_d = ((op_e == OP_DIV) & b_is_zero) ? a : '0;
        zero_d      = (basic_res == '0);
      end
    end else if ((state_q == ST_DONE) && out_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      remainder_q <= '0;
      zero_q      <= 1'b0;
      lt_q        <= 1'b0;
      ltu_q       <= 1'b0;
      overflow_q  <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      zero_q      <= zero_d;
      lt_q        <= lt_d;
      ltu_q       <= ltu_d;
      overflow_q  <= overflow_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign result    = result_q;
  assign remainder = remainder_q;
  assign zero      = zero_q;
  assign lt        = lt_q;
  assign ltu       = ltu_q;
  assign overflow  = overflow_q;
  assign div_zero  = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_multicycle
// Purpose : Self-checking bench for alu_multicycle (WIDTH=32). Directed
//           cases are followed by randomized ops, which are compared against
//           an arithmetic reference model.
// Config  : honours ALU_FAST_MUL_EN for the expected MUL latency.
// Revision: 1.0  initial release
// ============================================================================
module tb_alu_multicycle;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [W-1:0]  a, b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result, remainder;
  logic          zero, lt, ltu, overflow, div_zero;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .remainder (remainder),
    .zero      (zero),
    .lt        (lt),
    .ltu       (ltu),
    .overflow  (overflow),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: each op is computed from its arithmetic definition.
  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic [W-1:0] rm,
                       output logic ov, output logic dz, output int lat);
    longint sx, sy, s;
    longint unsigned ux, uy;
    int sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    sh = int'(y % 32);
    r = '0; rm = '0; ov = 1'b0; dz = 1'b0; lat = 1;
    case (o)
      4'h0: begin s = sx + sy; r = W'(s); ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'h1: begin s = sx - sy; r = W'(s); ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'h2: r = (x == y) ? 1 : 0;
      4'h3: r = (sx < sy) ? 1 : 0;
      4'h4: r = (sx > sy) ? 1 : 0;
      4'h5: r = x & y;
      4'h6: r = x | y;
      4'h7: r = ~x;
      4'h8: r = (ux < uy) ? 1 : 0;
      4'h9: r = (ux > uy) ? 1 : 0;
      4'hA, 4'hC: r = W'(ux * (64'd1 << sh));
      4'hB: r = W'(ux / (64'd1 << sh));
      4'hD: r = W'(sx >>> sh);
      4'hE: begin
        r = W'(ux * uy);
`ifdef ALU_FAST_MUL_EN
        lat = 1;
`else
        lat = W + 1;
`endif
      end
      default: begin
        if (y == 0) begin r = '1; rm = x; dz = 1'b1; lat = 1; end
        else begin r = W'(ux / uy); rm = W'(ux % uy); lat = W + 1; end
      end
    endcase
  endtask

  task automatic check_outs(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] r,
                            input logic [W-1:0] rm, input logic ov, input logic dz);
    check("out_valid", out_valid, 1);
    check("result", result, r);
    check("remainder", remainder, rm);
    check("zero", zero, r == 0);
    check("lt", lt, $signed(x) < $signed(y));
    check("ltu", ltu, x < y);
    check("overflow", overflow, ov);
    check("div_zero", div_zero, dz);
  endtask

  // Issue one op from idle, scramble the inputs after accept, wait for the
  // result, and hold out_ready low for 'stall' cycles before consuming it.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int stall);
    logic [W-1:0] r, rm;
    logic ov, dz;
    int exp_lat, lat, busy;
    model(o, x, y, r, rm, ov, dz, exp_lat);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1; busy = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("busy_cycles", busy, exp_lat - 1);
    for (int i = 0; i < stall; i++) begin
      check_outs(x, y, r, rm, ov, dz);
      check("in_ready_stall", in_ready, 0);
      @(posedge clk); #1;
    end
    check_outs(x, y, r, rm, ov, dz);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
  endtask

  logic [3:0]   ro;
  logic [W-1:0] ra, rb;
  int           cyc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {remainder, zero, lt, ltu, overflow, div_zero}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(4'h0, 32'h7FFF_FFFF, 32'h1, 0);
    run_op(4'hD, 32'h8000_0000, 32'h24, 0);
    run_op(4'hB, 32'h8000_0000, 32'h24, 0);
    run_op(4'hF, 32'd100, 32'd7, 1);
    run_op(4'hF, 32'd5, 32'd0, 0);
    run_op(4'h1, 32'h8000_0000, 32'h1, 0);
    run_op(4'hE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // MUL held for 5 cycles, then back-to-back accept of the next op
    @(negedge clk);
    in_valid = 1'b1; op = 4'hE; a = 32'h1_0000; b = 32'h1_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("mul_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("mul_hold_result", result, 0);
      check("mul_hold_zero", zero, 1);
      check("mul_hold_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; op = 4'h0; a = 32'd3; b = 32'd4;
    #1;
    check("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_valid", out_valid, 1);
    check("b2b_result", result, 7);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during DIV
    @(negedge clk);
    in_valid = 1'b1; op = 4'hF; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) cyc++;
    end
    check("no_stale_result", cyc, 0);
    check("post_rst_in_ready", in_ready, 1);

    // Randomized ops
    for (int n = 0; n < 40; n++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1:       rb = ra;
        2, 3, 4: rb = $urandom_range(0, 40);
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
